raw2rgb_demosaic: RTL and testbench

- Streaming Bayer-to-RGB converter for the camera path: next generation of the 2x2 binning front end.
- Accepts one raw pixel per valid cycle, keeps two lines internally, and forms a 3x3 window.
- Produces per-pixel R/G/B plus luma by either 3x3 bilinear interpolation or 2x2 bin.
- Bayer phase, mode and pixel widths are configurable; output feeds the frame buffer and VGA path.

---
 rtl/raw2rgb_pkg.sv | 20 ++
 rtl/raw2rgb_demosaic_line_buffer.sv | 29 ++
 rtl/raw2rgb_demosaic.sv | 228 ++++++++++++++++++++++
 tb/tb_raw2rgb_demosaic.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/raw2rgb_pkg.sv
// rtl/raw2rgb_pkg.sv - shared constants and types for the Bayer demosaic
// Purpose: colour-site encoding, mode encoding, FSM state type and pipeline latency.
// Ports: none (package).
package raw2rgb_pkg;

  // Colour site at the window centre. The values double as XOR offsets inside
  // a 2x2 block: bit 0 steps one column, bit 1 steps one row.
  localparam logic [1:0] SITE_R  = 2'd0;
  localparam logic [1:0] SITE_GR = 2'd1;
  localparam logic [1:0] SITE_GB = 2'd2;
  localparam logic [1:0] SITE_B  = 2'd3;

  localparam logic MODE_BIN      = 1'b0;
  localparam logic MODE_BILINEAR = 1'b1;

  localparam int PIPE_LAT = 2;

  typedef enum logic {IDLE, ACTIVE} demosaicState_t;

endpackage

// File: rtl/raw2rgb_demosaic_line_buffer.sv
// rtl/raw2rgb_demosaic_line_buffer.sv - one-line pixel store with synchronous read
// Purpose: MAX_W x DATA_W dual-port RAM; one write port, one read port.
//   A read and a write to the same address in one cycle returns the old word.
// Ports: CLK; wrEn/wrAddr/wrData write side; rdEn/rdAddr read request,
//   rdData registered read word (holds when rdEn is low).
import raw2rgb_pkg::*;

module rgb_line_buffer #(
  parameter int DATA_W = 10,
  parameter int MAX_W  = 1024,
  parameter int AW     = 10
) (
  input  logic              CLK,
  input  logic              wrEn,
  input  logic [AW-1:0]     wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [AW-1:0]     rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [MAX_W];

  always_ff @(posedge CLK) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/raw2rgb_demosaic.sv
// rtl/raw2rgb_demosaic.sv - streaming Bayer-to-RGB converter, bilinear or 2x2 bin
// Purpose: one raw pixel in per valid cycle, one RGB + luma pixel out 2 cycles later
//   for every window centre at least one pixel in from the frame edge.
// Ports: CLK, RESET_N (sync, active low); iDATA/iDVAL/iSOF/iSOL raw stream;
//   iMODE, iBAYER latched at iSOF; oRed/oGreen/oBlue/oGray/oDVAL/oSOF/oSOL output
//   stream; oOVF sticky line-overflow flag.
import raw2rgb_pkg::*;

module raw2rgb_demosaic #(
  parameter int DATA_W = 10,
  parameter int OUT_W  = 8,
  parameter int MAX_W  = 1024,
  parameter int XW     = 11
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic              iSOL,
  input  logic              iMODE,
  input  logic [1:0]        iBAYER,
  output logic [OUT_W-1:0]  oRed,
  output logic [OUT_W-1:0]  oGreen,
  output logic [OUT_W-1:0]  oBlue,
  output logic [OUT_W-1:0]  oGray,
  output logic              oDVAL,
  output logic              oSOF,
  output logic              oSOL,
  output logic              oOVF
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int SW = DATA_W + 2;
  localparam int GW = OUT_W + 2;
  localparam logic [XW-1:0] XMAX  = '1;
  localparam logic [XW:0]   MAX_X = (XW+1)'(MAX_W);

  demosaicState_t state, nextState;
  logic accept;

  logic [XW-1:0] colCnt, rowCnt, curX, curY;
  logic          modeReg, modeEff, ovfPix, inRange, outPix;
  logic [1:0]    bayerReg, bayerEff, siteIdx;

  logic              s1Valid, s1Out, s1Sof, s1Sol, s1Mode;
  logic [1:0]        s1Site;
  logic [DATA_W-1:0] s1Data;
  logic [AW-1:0]     s1Addr;
  logic              s2Valid, s2Sof, s2Sol, s2Mode;
  logic [1:0]        s2Site;
  logic [DATA_W-1:0] row1Data, row2Data;

  // Index 2 is the newest column (x), 1 the centre column, 0 the oldest.
  logic [DATA_W-1:0] wTop [3];
  logic [DATA_W-1:0] wMid [3];
  logic [DATA_W-1:0] wBot [3];

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        accept = iDVAL & iSOF;
        if (iDVAL & iSOF) nextState = ACTIVE;
      end
      ACTIVE: accept = iDVAL;
      default: nextState = IDLE;
    endcase
  end

  // Coordinates of the pixel on iDATA this cycle; iSOF takes priority over iSOL.
  always_comb begin
    curX = colCnt;
    curY = rowCnt;
    if (iSOF) begin
      curX = '0;
      curY = '0;
    end else if (iSOL) begin
      curX = '0;
      curY = (rowCnt == XMAX) ? rowCnt : rowCnt + 1'b1;
    end
    modeEff  = iSOF ? iMODE : modeReg;
    bayerEff = iSOF ? iBAYER : bayerReg;
    ovfPix   = {1'b0, curX} >= MAX_X;
    inRange  = accept & ~ovfPix;
    outPix   = (curX >= XW'(2)) && (curY >= XW'(2));
    // Centre is (x-1, y-1), so its parity is the inverse of the incoming pixel's.
    siteIdx  = bayerEff ^ {~curY[0], ~curX[0]};
  end

  rgb_line_buffer #(.DATA_W(DATA_W), .MAX_W(MAX_W), .AW(AW)) lineBuf1 (
    .CLK(CLK), .wrEn(inRange), .wrAddr(curX[AW-1:0]), .wrData(iDATA),
    .rdEn(inRange), .rdAddr(curX[AW-1:0]), .rdData(row1Data)
  );

  // Row y-2 is refilled one cycle later from the row y-1 word just read out.
  rgb_line_buffer #(.DATA_W(DATA_W), .MAX_W(MAX_W), .AW(AW)) lineBuf2 (
    .CLK(CLK), .wrEn(s1Valid), .wrAddr(s1Addr), .wrData(row1Data),
    .rdEn(inRange), .rdAddr(curX[AW-1:0]), .rdData(row2Data)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state    <= IDLE;
      colCnt   <= '0;
      rowCnt   <= '0;
      modeReg  <= MODE_BIN;
      bayerReg <= SITE_R;
      s1Valid  <= 1'b0;
      s1Out    <= 1'b0;
      s1Sof    <= 1'b0;
      s1Sol    <= 1'b0;
      s1Mode   <= MODE_BIN;
      s1Site   <= SITE_R;
      s1Data   <= '0;
      s1Addr   <= '0;
      s2Valid  <= 1'b0;
      s2Sof    <= 1'b0;
      s2Sol    <= 1'b0;
      s2Mode   <= MODE_BIN;
      s2Site   <= SITE_R;
      oOVF     <= 1'b0;
    end else begin
      state   <= nextState;
      s1Valid <= inRange;
      s2Valid <= s1Valid & s1Out;
      if (accept) begin
        colCnt <= (curX == XMAX) ? curX : curX + 1'b1;
        rowCnt <= curY;
        if (iSOF) begin
          modeReg  <= iMODE;
          bayerReg <= iBAYER;
          oOVF     <= 1'b0;
        end else if (ovfPix) begin
          oOVF <= 1'b1;
        end
      end
      if (inRange) begin
        s1Out  <= outPix;
        s1Sof  <= (curX == XW'(2)) && (curY == XW'(2));
        s1Sol  <= curX == XW'(2);
        s1Mode <= modeEff;
        s1Site <= siteIdx;
        s1Data <= iDATA;
        s1Addr <= curX[AW-1:0];
      end
      if (s1Valid) begin
        s2Sof  <= s1Sof;
        s2Sol  <= s1Sol;
        s2Mode <= s1Mode;
        s2Site <= s1Site;
      end
    end
  end

  // Window only moves on accepted pixels, so input gaps simply stall it.
  always_ff @(posedge CLK) begin
    if (s1Valid) begin
      for (int i = 0; i < 2; i++) begin
        wTop[i] <= wTop[i+1];
        wMid[i] <= wMid[i+1];
        wBot[i] <= wBot[i+1];
      end
      wTop[2] <= row2Data;
      wMid[2] <= row1Data;
      wBot[2] <= s1Data;
    end
  end

  logic [DATA_W-1:0] blk [4];
  logic [DATA_W-1:0] edgeAvg, diagAvg, nsAvg, weAvg, binG, chR, chG, chB;
  logic [OUT_W-1:0]  outR, outG, outB;

  always_comb begin
    // 2x2 bin block with the centre at top-left; index = {row step, column step}.
    blk[0]  = wMid[1];
    blk[1]  = wMid[2];
    blk[2]  = wBot[1];
    blk[3]  = wBot[2];
    edgeAvg = DATA_W'((SW'(wTop[1]) + SW'(wBot[1]) + SW'(wMid[0]) + SW'(wMid[2])) >> 2);
    diagAvg = DATA_W'((SW'(wTop[0]) + SW'(wTop[2]) + SW'(wBot[0]) + SW'(wBot[2])) >> 2);
    nsAvg   = DATA_W'((SW'(wTop[1]) + SW'(wBot[1])) >> 1);
    weAvg   = DATA_W'((SW'(wMid[0]) + SW'(wMid[2])) >> 1);
    binG    = DATA_W'((SW'(blk[s2Site ^ SITE_GR]) + SW'(blk[s2Site ^ SITE_GB])) >> 1);
    chR     = wMid[1];
    chG     = wMid[1];
    chB     = wMid[1];
    if (s2Mode == MODE_BIN) begin
      chR = blk[s2Site];
      chG = binG;
      chB = blk[s2Site ^ SITE_B];
    end else begin
      case (s2Site)
        SITE_R:  begin chG = edgeAvg; chB = diagAvg; end
        SITE_GR: begin chR = weAvg;   chB = nsAvg;   end
        SITE_GB: begin chR = nsAvg;   chB = weAvg;   end
        default: begin chR = diagAvg; chG = edgeAvg; end
      endcase
    end
    outR = OUT_W'(chR >> (DATA_W - OUT_W));
    outG = OUT_W'(chG >> (DATA_W - OUT_W));
    outB = OUT_W'(chB >> (DATA_W - OUT_W));
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
      oGray  <= '0;
      oDVAL  <= 1'b0;
      oSOF   <= 1'b0;
      oSOL   <= 1'b0;
    end else begin
      oDVAL <= s2Valid;
      oSOF  <= s2Valid & s2Sof;
      oSOL  <= s2Valid & s2Sol;
      if (s2Valid) begin
        oRed   <= outR;
        oGreen <= outG;
        oBlue  <= outB;
        oGray  <= OUT_W'((GW'(outR) + (GW'(outG) << 1) + GW'(outB)) >> 2);
      end
    end
  end

endmodule

// File: tb/tb_raw2rgb_demosaic.sv
// tb/tb_raw2rgb_demosaic.sv - directed self-checking bench for raw2rgb_demosaic
module tb_raw2rgb_demosaic;

  logic       CLK;
  logic       RESET_N;
  logic [9:0] iDATA;
  logic       iDVAL, iSOF, iSOL, iMODE;
  logic [1:0] iBAYER;
  logic [7:0] oRed, oGreen, oBlue, oGray;
  logic       oDVAL, oSOF, oSOL, oOVF;

  raw2rgb_demosaic #(.DATA_W(10), .OUT_W(8), .MAX_W(8), .XW(11)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
    .iSOL(iSOL), .iMODE(iMODE), .iBAYER(iBAYER), .oRed(oRed), .oGreen(oGreen),
    .oBlue(oBlue), .oGray(oGray), .oDVAL(oDVAL), .oSOF(oSOF), .oSOL(oSOL), .oOVF(oOVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vecCnt = 0;
  int failCnt = 0;
  int outCnt, sofCnt, solCnt;
  logic p1v, p2v, p1s, p2s, p1l, p2l, ovfM;
  logic [7:0] expR, expG, expB, expGray;
  string curTag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s %s: observed %0d, expected %0d", curTag, tag, obs, exp);
    end
  endtask

  // Scene: -1 = flat 512, otherwise the Bayer phase of a R=1000/G=500/B=100 pattern.
  function automatic logic [9:0] pix(input int scene, input int x, input int y);
    logic [1:0] idx;
    if (scene < 0) return 10'd512;
    idx = 2'(scene) ^ {y[0], x[0]};
    case (idx)
      2'd0:    return 10'd1000;
      2'd3:    return 10'd100;
      default: return 10'd500;
    endcase
  endfunction

  // One clock: drive, take the edge, then check outputs against what was
  // expected from the pixel accepted two edges earlier.
  task automatic step(input logic rst, input logic dv, input logic sof, input logic sol,
                      input logic [9:0] d, input logic eo, input logic es,
                      input logic el, input logic ov);
    RESET_N = ~rst; iDVAL = dv; iSOF = sof; iSOL = sol; iDATA = d;
    @(posedge CLK);
    #1;
    RESET_N = 1'b1; iDVAL = 1'b0; iSOF = 1'b0; iSOL = 1'b0;
    if (rst) begin
      {p1v, p2v, p1s, p2s, p1l, p2l, ovfM} = '0;
      chk("rst.oDVAL", oDVAL, 0);
      chk("rst.oSOF", oSOF, 0);
      chk("rst.oSOL", oSOL, 0);
      chk("rst.oOVF", oOVF, 0);
      chk("rst.oRed", oRed, 0);
      chk("rst.oGreen", oGreen, 0);
      chk("rst.oBlue", oBlue, 0);
      chk("rst.oGray", oGray, 0);
    end else begin
      if (dv && sof) ovfM = 1'b0;
      else if (dv && ov) ovfM = 1'b1;
      chk("oDVAL", oDVAL, p2v);
      chk("oSOF", oSOF, p2v & p2s);
      chk("oSOL", oSOL, p2v & p2l);
      chk("oOVF", oOVF, ovfM);
      if (p2v) begin
        outCnt++;
        if (p2s) sofCnt++;
        if (p2l) solCnt++;
        chk("oRed", oRed, expR);
        chk("oGreen", oGreen, expG);
        chk("oBlue", oBlue, expB);
        chk("oGray", oGray, expGray);
      end
      p2v = p1v; p2s = p1s; p2l = p1l;
      p1v = dv & eo; p1s = es; p1l = el;
    end
  endtask

  task automatic setExp(input string tag, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic [7:0] gr);
    curTag = tag; expR = r; expG = g; expB = b; expGray = gr;
    outCnt = 0; sofCnt = 0; solCnt = 0;
  endtask

  // MAX_W is 8 in this bench, so x >= 8 overflows and never produces an output.
  task automatic runFrame(input string tag, input int w, input int h, input logic md,
                          input logic [1:0] by, input int scene, input bit gaps,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic [7:0] gr, input int expCnt);
    setExp(tag, r, g, b, gr);
    iMODE = md; iBAYER = by;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        step(1'b0, 1'b1, (x == 0 && y == 0), (x == 0 && y > 0), pix(scene, x, y),
             (x >= 2 && y >= 2 && x < 8), (x == 2 && y == 2), (x == 2), (x >= 8));
        if (gaps) step(1'b0, 1'b0, 1'b0, 1'b0, 10'h3ff, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("outCount", outCnt, expCnt);
    chk("sofCount", sofCnt, 1);
    chk("solCount", solCnt, h - 2);
  endtask

  initial begin
    RESET_N = 1'b0; iDVAL = 1'b0; iSOF = 1'b0; iSOL = 1'b0;
    iDATA = '0; iMODE = 1'b0; iBAYER = 2'd0;
    {p1v, p2v, p1s, p2s, p1l, p2l, ovfM} = '0;
    curTag = "reset";
    repeat (3) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    chk("oDVAL", oDVAL, 0);
    chk("oSOF", oSOF, 0);
    chk("oSOL", oSOL, 0);
    chk("oOVF", oOVF, 0);
    chk("oRed", oRed, 0);
    chk("oGreen", oGreen, 0);
    chk("oBlue", oBlue, 0);
    chk("oGray", oGray, 0);

    runFrame("flat6x4", 6, 4, 1'b1, 2'd0, -1, 1'b0, 8'd128, 8'd128, 8'd128, 8'd128, 8);

    for (int bm = 0; bm < 8; bm++)
      runFrame($sformatf("uniform.bayer%0d.mode%0d", bm % 4, bm / 4), 8, 6, 1'(bm / 4),
               2'(bm % 4), bm % 4, 1'b0, 8'd250, 8'd125, 8'd25, 8'd131, 24);

    runFrame("wrongPhase.bilinear", 8, 6, 1'b1, 2'd3, 0, 1'b0, 8'd25, 8'd125, 8'd250, 8'd131, 24);
    runFrame("wrongPhase.bin", 8, 6, 1'b0, 2'd3, 0, 1'b0, 8'd25, 8'd125, 8'd250, 8'd131, 24);

    runFrame("stall8x6", 8, 6, 1'b1, 2'd0, -1, 1'b1, 8'd128, 8'd128, 8'd128, 8'd128, 24);

    // Reset during input row 3; the rest of that frame must be ignored.
    setExp("midReset", 8'd128, 8'd128, 8'd128, 8'd128);
    iMODE = 1'b1; iBAYER = 2'd0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) begin
        if (y == 3 && x == 3)
          step(1'b1, 1'b1, 1'b0, 1'b0, 10'd512, 1'b0, 1'b0, 1'b0, 1'b0);
        else if (y == 3 && x > 3)
          step(1'b0, 1'b1, 1'b0, 1'b0, 10'd512, 1'b0, 1'b0, 1'b0, 1'b0);
        else
          step(1'b0, 1'b1, (x == 0 && y == 0), (x == 0 && y > 0), 10'd512,
               (x >= 2 && y >= 2), (x == 2 && y == 2), (x == 2), 1'b0);
      end
    for (int y = 4; y < 6; y++)
      for (int x = 0; x < 8; x++)
        step(1'b0, 1'b1, 1'b0, (x == 0), 10'd512, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("preResetOutputs", outCnt, 6);
    chk("ovfAfterReset", oOVF, 0);
    runFrame("afterReset", 6, 4, 1'b1, 2'd0, -1, 1'b0, 8'd128, 8'd128, 8'd128, 8'd128, 8);

    runFrame("overflow10x4", 10, 4, 1'b1, 2'd0, -1, 1'b0, 8'd128, 8'd128, 8'd128, 8'd128, 12);
    chk("ovfSticky", oOVF, 1);
    runFrame("ovfCleared", 6, 4, 1'b0, 2'd1, 1, 1'b0, 8'd250, 8'd125, 8'd25, 8'd131, 8);
    chk("ovfClearedEnd", oOVF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, failCnt);
    $finish;
  end

endmodule
